// File: rtl/id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_ex_stage : ID/EX pipeline register with load-use hazard detection,      |
// |               bubble insertion on stall/flush and saturating event counters |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module id_ex_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      id_valid,
   input  logic                      id_reg_dst,
   input  logic                      id_jump,
   input  logic                      id_branch,
   input  logic                      id_branch_bne,
   input  logic                      id_mem_read,
   input  logic                      id_mem_to_reg,
   input  logic                      id_mem_write,
   input  logic                      id_alu_src,
   input  logic                      id_reg_write,
   input  logic [3:0]                id_alu_op,
   input  logic [DATA_WIDTH-1:0]     id_pc_plus4,
   input  logic [DATA_WIDTH-1:0]     id_rs_data,
   input  logic [DATA_WIDTH-1:0]     id_rt_data,
   input  logic [DATA_WIDTH-1:0]     id_imm,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs,
   input  logic [REG_ADDR_WIDTH-1:0] id_rt,
   input  logic [REG_ADDR_WIDTH-1:0] id_rd,
   input  logic [5:0]                id_funct,
   input  logic                      flush,
   output logic                      ex_valid,
   output logic                      ex_reg_dst,
   output logic                      ex_jump,
   output logic                      ex_branch,
   output logic                      ex_branch_bne,
   output logic                      ex_mem_read,
   output logic                      ex_mem_to_reg,
   output logic                      ex_mem_write,
   output logic                      ex_alu_src,
   output logic                      ex_reg_write,
   output logic [3:0]                ex_alu_op,
   output logic [DATA_WIDTH-1:0]     ex_pc_plus4,
   output logic [DATA_WIDTH-1:0]     ex_rs_data,
   output logic [DATA_WIDTH-1:0]     ex_rt_data,
   output logic [DATA_WIDTH-1:0]     ex_imm,
   output logic [REG_ADDR_WIDTH-1:0] ex_rs,
   output logic [REG_ADDR_WIDTH-1:0] ex_rt,
   output logic [5:0]                ex_funct,
   output logic [REG_ADDR_WIDTH-1:0] ex_write_reg,
   output logic                      stall,
   output logic                      pc_write,
   output logic                      if_id_write,
   output logic [CNT_WIDTH-1:0]      stall_count,
   output logic [CNT_WIDTH-1:0]      flush_count
);

   typedef struct packed {
      logic       reg_dst;
      logic       jump;
      logic       branch;
      logic       branch_bne;
      logic       mem_read;
      logic       mem_to_reg;
      logic       mem_write;
      logic       alu_src;
      logic       reg_write;
      logic [3:0] alu_op;
   } ctrl_t;

   ctrl_t                     ctrl_d, ctrl_q;
   logic                      valid_d, valid_q;
   logic [REG_ADDR_WIDTH-1:0] write_reg_d, write_reg_q;
   logic [DATA_WIDTH-1:0]     pc_plus4_d, pc_plus4_q;
   logic [DATA_WIDTH-1:0]     rs_data_d, rs_data_q;
   logic [DATA_WIDTH-1:0]     rt_data_d, rt_data_q;
   logic [DATA_WIDTH-1:0]     imm_d, imm_q;
   logic [REG_ADDR_WIDTH-1:0] rs_d, rs_q;
   logic [REG_ADDR_WIDTH-1:0] rt_d, rt_q;
   logic [5:0]                funct_d, funct_q;
   logic [CNT_WIDTH-1:0]      stall_cnt_d, stall_cnt_q;
   logic [CNT_WIDTH-1:0]      flush_cnt_d, flush_cnt_q;

   logic uses_rt;
   logic load_in_ex;
   logic hazard;

   // rt is only a source for R-type, branches and stores; for lw/I-type ALU it is the destination.
   assign uses_rt    = id_valid & (id_reg_dst | id_branch | id_branch_bne | id_mem_write);
   assign load_in_ex = valid_q & ctrl_q.mem_read & (write_reg_q != '0);
   assign hazard     = load_in_ex
                     & ((id_valid & (write_reg_q == id_rs)) | (uses_rt & (write_reg_q == id_rt)))
                     & ~flush;

   assign stall       = hazard;
   assign pc_write    = ~hazard;
   assign if_id_write = ~hazard;

   always_comb begin
      valid_d     = id_valid;
      ctrl_d      = '{reg_dst: id_reg_dst, jump: id_jump, branch: id_branch,
                      branch_bne: id_branch_bne, mem_read: id_mem_read,
                      mem_to_reg: id_mem_to_reg, mem_write: id_mem_write,
                      alu_src: id_alu_src, reg_write: id_reg_write, alu_op: id_alu_op};
      write_reg_d = id_reg_dst ? id_rd : id_rt;
      pc_plus4_d  = id_pc_plus4;
      rs_data_d   = id_rs_data;
      rt_data_d   = id_rt_data;
      imm_d       = id_imm;
      rs_d        = id_rs;
      rt_d        = id_rt;
      funct_d     = id_funct;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      // A bubble clears every control that could cause a side effect; data fields ride along.
      if (flush || hazard) begin
         valid_d     = 1'b0;
         ctrl_d      = '0;
         write_reg_d = '0;
      end
      if (flush) begin
         flush_cnt_d = (&flush_cnt_q) ? flush_cnt_q : flush_cnt_q + 1'b1;
      end else if (hazard) begin
         stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q     <= 1'b0;
         ctrl_q      <= '0;
         write_reg_q <= '0;
         pc_plus4_q  <= '0;
         rs_data_q   <= '0;
         rt_data_q   <= '0;
         imm_q       <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         funct_q     <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         valid_q     <= valid_d;
         ctrl_q      <= ctrl_d;
         write_reg_q <= write_reg_d;
         pc_plus4_q  <= pc_plus4_d;
         rs_data_q   <= rs_data_d;
         rt_data_q   <= rt_data_d;
         imm_q       <= imm_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         funct_q     <= funct_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign ex_valid      = valid_q;
   assign ex_reg_dst    = ctrl_q.reg_dst;
   assign ex_jump       = ctrl_q.jump;
   assign ex_branch     = ctrl_q.branch;
   assign ex_branch_bne = ctrl_q.branch_bne;
   assign ex_mem_read   = ctrl_q.mem_read;
   assign ex_mem_to_reg = ctrl_q.mem_to_reg;
   assign ex_mem_write  = ctrl_q.mem_write;
   assign ex_alu_src    = ctrl_q.alu_src;
   assign ex_reg_write  = ctrl_q.reg_write;
   assign ex_alu_op     = ctrl_q.alu_op;
   assign ex_write_reg  = write_reg_q;
   assign ex_pc_plus4   = pc_plus4_q;
   assign ex_rs_data    = rs_data_q;
   assign ex_rt_data    = rt_data_q;
   assign ex_imm        = imm_q;
   assign ex_rs         = rs_q;
   assign ex_rt         = rt_q;
   assign ex_funct      = funct_q;
   assign stall_count   = stall_cnt_q;
   assign flush_count   = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_id_ex_stage : scoreboard bench for id_ex_stage with a pipeline model     |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
module tb_id_ex_stage;

   localparam int K_NOP = 0, K_ADD = 1, K_LW = 2, K_ADDI = 3, K_SW = 4, K_BEQ = 5, K_BNE = 6, K_J = 7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0, reg_dst = 1'b0, jump = 1'b0, branch = 1'b0, bne = 1'b0;
   logic        mem_read = 1'b0, mem_to_reg = 1'b0, mem_write = 1'b0, alu_src = 1'b0, reg_write = 1'b0;
   logic [3:0]  alu_op = '0;
   logic [31:0] pc = '0, rsd = '0, rtd = '0, imm = '0;
   logic [4:0]  rs = '0, rt = '0, rd = '0;
   logic [5:0]  funct = '0;
   logic        flush = 1'b0;

   logic        o_valid, o_reg_dst, o_jump, o_branch, o_bne, o_mem_read, o_mem_to_reg;
   logic        o_mem_write, o_alu_src, o_reg_write, o_stall, o_pc_write, o_if_id_write;
   logic [3:0]  o_alu_op;
   logic [31:0] o_pc, o_rsd, o_rtd, o_imm;
   logic [4:0]  o_rs, o_rt, o_wr;
   logic [5:0]  o_funct;
   logic [15:0] o_sc, o_fc;

   logic        p_valid, p_reg_dst, p_jump, p_branch, p_bne, p_mem_read, p_mem_to_reg;
   logic        p_mem_write, p_alu_src, p_reg_write, p_stall, p_pc_write, p_if_id_write;
   logic [3:0]  p_alu_op;
   logic [31:0] p_pc, p_rsd, p_rtd, p_imm;
   logic [4:0]  p_rs, p_rt, p_wr;
   logic [5:0]  p_funct;
   logic [1:0]  p_sc, p_fc;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .reset(rst), .id_valid(valid), .id_reg_dst(reg_dst), .id_jump(jump),
      .id_branch(branch), .id_branch_bne(bne), .id_mem_read(mem_read), .id_mem_to_reg(mem_to_reg),
      .id_mem_write(mem_write), .id_alu_src(alu_src), .id_reg_write(reg_write), .id_alu_op(alu_op),
      .id_pc_plus4(pc), .id_rs_data(rsd), .id_rt_data(rtd), .id_imm(imm), .id_rs(rs), .id_rt(rt),
      .id_rd(rd), .id_funct(funct), .flush(flush),
      .ex_valid(o_valid), .ex_reg_dst(o_reg_dst), .ex_jump(o_jump), .ex_branch(o_branch),
      .ex_branch_bne(o_bne), .ex_mem_read(o_mem_read), .ex_mem_to_reg(o_mem_to_reg),
      .ex_mem_write(o_mem_write), .ex_alu_src(o_alu_src), .ex_reg_write(o_reg_write),
      .ex_alu_op(o_alu_op), .ex_pc_plus4(o_pc), .ex_rs_data(o_rsd), .ex_rt_data(o_rtd),
      .ex_imm(o_imm), .ex_rs(o_rs), .ex_rt(o_rt), .ex_funct(o_funct), .ex_write_reg(o_wr),
      .stall(o_stall), .pc_write(o_pc_write), .if_id_write(o_if_id_write),
      .stall_count(o_sc), .flush_count(o_fc)
   );

   id_ex_stage #(.CNT_WIDTH(2)) dut_sat (
      .clk(clk), .reset(rst), .id_valid(valid), .id_reg_dst(reg_dst), .id_jump(jump),
      .id_branch(branch), .id_branch_bne(bne), .id_mem_read(mem_read), .id_mem_to_reg(mem_to_reg),
      .id_mem_write(mem_write), .id_alu_src(alu_src), .id_reg_write(reg_write), .id_alu_op(alu_op),
      .id_pc_plus4(pc), .id_rs_data(rsd), .id_rt_data(rtd), .id_imm(imm), .id_rs(rs), .id_rt(rt),
      .id_rd(rd), .id_funct(funct), .flush(flush),
      .ex_valid(p_valid), .ex_reg_dst(p_reg_dst), .ex_jump(p_jump), .ex_branch(p_branch),
      .ex_branch_bne(p_bne), .ex_mem_read(p_mem_read), .ex_mem_to_reg(p_mem_to_reg),
      .ex_mem_write(p_mem_write), .ex_alu_src(p_alu_src), .ex_reg_write(p_reg_write),
      .ex_alu_op(p_alu_op), .ex_pc_plus4(p_pc), .ex_rs_data(p_rsd), .ex_rt_data(p_rtd),
      .ex_imm(p_imm), .ex_rs(p_rs), .ex_rt(p_rt), .ex_funct(p_funct), .ex_write_reg(p_wr),
      .stall(p_stall), .pc_write(p_pc_write), .if_id_write(p_if_id_write),
      .stall_count(p_sc), .flush_count(p_fc)
   );

   // Expected contents of the EX stage after one edge, plus the hazard seen before that edge.
   typedef struct {
      bit        stall;
      bit        chk_data;
      bit        valid, reg_dst, jump, branch, bne, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
      bit [3:0]  alu_op;
      bit [4:0]  wr, rs, rt;
      bit [5:0]  funct;
      bit [31:0] pc, rsd, rtd, imm;
      int        sc, fc, sc2, fc2;
   } exp_t;

   exp_t sb[$];
   exp_t m;
   int   n_chk  = 0;
   int   n_pass = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endfunction

   function automatic int sat(int v, int mx);
      return (v < mx) ? v + 1 : v;
   endfunction

   function automatic exp_t empty_stage();
      exp_t z;
      z.stall = 0; z.chk_data = 1;
      z.valid = 0; z.reg_dst = 0; z.jump = 0; z.branch = 0; z.bne = 0; z.mem_read = 0;
      z.mem_to_reg = 0; z.mem_write = 0; z.alu_src = 0; z.reg_write = 0; z.alu_op = 0;
      z.wr = 0; z.rs = 0; z.rt = 0; z.funct = 0; z.pc = 0; z.rsd = 0; z.rtd = 0; z.imm = 0;
      z.sc = 0; z.fc = 0; z.sc2 = 0; z.fc2 = 0;
      return z;
   endfunction

   task automatic set_instr(int kind, int s, int t, int d);
      rst = 0; flush = 0; valid = 1;
      {reg_dst, jump, branch, bne, mem_read, mem_to_reg, mem_write, alu_src, reg_write} = '0;
      alu_op = 4'b0000;
      rs = 5'(s); rt = 5'(t); rd = 5'(d);
      funct = 6'($urandom); pc = $urandom; rsd = $urandom; rtd = $urandom; imm = $urandom;
      case (kind)
         K_NOP: begin
            valid = 0;
            {reg_dst, jump, branch, bne, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op} = 13'($urandom);
         end
         K_ADD:  begin reg_dst = 1; reg_write = 1; alu_op = 4'b0010; end
         K_LW:   begin mem_read = 1; mem_to_reg = 1; alu_src = 1; reg_write = 1; alu_op = 4'b0010; end
         K_ADDI: begin alu_src = 1; reg_write = 1; alu_op = 4'b0010; end
         K_SW:   begin mem_write = 1; alu_src = 1; alu_op = 4'b0010; end
         K_BEQ:  begin branch = 1; alu_op = 4'b0110; end
         K_BNE:  begin bne = 1; alu_op = 4'b0110; end
         default: jump = 1;
      endcase
   endtask

   // Reference model: a load in EX blocks any ID instruction that reads its destination.
   task automatic step();
      exp_t n;
      bit   reads_rt, hz;
      reads_rt = valid && (reg_dst || branch || bne || mem_write);
      hz = m.valid && m.mem_read && (m.wr != 0)
           && ((valid && m.wr == rs) || (reads_rt && m.wr == rt)) && !flush;
      if (rst) begin
         n = empty_stage();
      end else begin
         n = m;
         n.chk_data = 1;
         n.valid = valid; n.reg_dst = reg_dst; n.jump = jump; n.branch = branch; n.bne = bne;
         n.mem_read = mem_read; n.mem_to_reg = mem_to_reg; n.mem_write = mem_write;
         n.alu_src = alu_src; n.reg_write = reg_write; n.alu_op = alu_op;
         n.wr = reg_dst ? rd : rt;
         n.rs = rs; n.rt = rt; n.funct = funct; n.pc = pc; n.rsd = rsd; n.rtd = rtd; n.imm = imm;
         if (flush || hz) begin
            n.chk_data = 0;
            n.valid = 0; n.reg_dst = 0; n.jump = 0; n.branch = 0; n.bne = 0; n.mem_read = 0;
            n.mem_to_reg = 0; n.mem_write = 0; n.alu_src = 0; n.reg_write = 0; n.alu_op = 0; n.wr = 0;
            if (flush) begin n.fc = sat(n.fc, 65535); n.fc2 = sat(n.fc2, 3); end
            else       begin n.sc = sat(n.sc, 65535); n.sc2 = sat(n.sc2, 3); end
         end
      end
      n.stall = hz;
      sb.push_back(n);
      m = n;
      @(negedge clk);
   endtask

   // Monitor: hazard outputs mid-low-phase, registered outputs just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk); #2;
         if (sb.size() != 0) begin
            e = sb[0];
            chk("stall",       o_stall,       e.stall);
            chk("pc_write",    o_pc_write,    !e.stall);
            chk("if_id_write", o_if_id_write, !e.stall);
            chk("stall_w2",    p_stall,       e.stall);
            @(posedge clk); #1;
            void'(sb.pop_front());
            chk("ex_valid",      o_valid,      e.valid);
            chk("ex_reg_dst",    o_reg_dst,    e.reg_dst);
            chk("ex_jump",       o_jump,       e.jump);
            chk("ex_branch",     o_branch,     e.branch);
            chk("ex_branch_bne", o_bne,        e.bne);
            chk("ex_mem_read",   o_mem_read,   e.mem_read);
            chk("ex_mem_to_reg", o_mem_to_reg, e.mem_to_reg);
            chk("ex_mem_write",  o_mem_write,  e.mem_write);
            chk("ex_reg_write",  o_reg_write,  e.reg_write);
            chk("ex_alu_op",     o_alu_op,     e.alu_op);
            chk("ex_write_reg",  o_wr,         e.wr);
            chk("stall_count",   o_sc,         e.sc);
            chk("flush_count",   o_fc,         e.fc);
            chk("stall_count_w2", p_sc,        e.sc2);
            chk("flush_count_w2", p_fc,        e.fc2);
            chk("ex_valid_w2",    p_valid,     e.valid);
            if (e.chk_data) begin
               chk("ex_alu_src",  o_alu_src, e.alu_src);
               chk("ex_pc_plus4", o_pc,      e.pc);
               chk("ex_rs_data",  o_rsd,     e.rsd);
               chk("ex_rt_data",  o_rtd,     e.rtd);
               chk("ex_imm",      o_imm,     e.imm);
               chk("ex_rs",       o_rs,      e.rs);
               chk("ex_rt",       o_rt,      e.rt);
               chk("ex_funct",    o_funct,   e.funct);
            end
         end
      end
   end

   initial begin
      int k;
      m = empty_stage();
      @(negedge clk);
      // Reset with arbitrary decode inputs
      repeat (2) begin set_instr($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31)); rst = 1; flush = 1'($urandom); step(); end
      // Pass-through add
      set_instr(K_ADD, 1, 2, 3); step();
      // Load-use: lw r5, then add using r5 held for the stall cycle
      set_instr(K_LW, 6, 5, 0); step();
      set_instr(K_ADD, 5, 7, 8); step(); step();
      // Back-to-back dependent loads
      set_instr(K_LW, 1, 6, 0);  step();
      set_instr(K_LW, 6, 9, 0);  step(); step();
      set_instr(K_SW, 2, 9, 0);  step(); step();
      // rt as destination, and r0 loads, never stall
      set_instr(K_LW, 6, 5, 0);  step();
      set_instr(K_ADDI, 6, 5, 0); step();
      set_instr(K_LW, 6, 0, 0);  step();
      set_instr(K_ADD, 0, 0, 4); step();
      // Flush overrides a load-use hazard
      set_instr(K_LW, 6, 5, 0);  step();
      set_instr(K_ADD, 5, 2, 3); flush = 1; step();
      // Counter saturation on the narrow-counter instance
      set_instr(K_NOP, 0, 0, 0); rst = 1; step();
      repeat (5) begin set_instr(K_J, 0, 0, 0); flush = 1; step(); end
      // Randomized traffic over a small register set to provoke hazards
      for (int i = 0; i < 400; i++) begin
         k = $urandom_range(0, 9);
         set_instr((k > 7) ? K_LW : k, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         flush = ($urandom_range(0, 7) == 0);
         rst   = ($urandom_range(0, 63) == 0);
         step();
      end
      for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
      #2;
      chk("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
